// File: rtl/target_identity_pkg.sv
// Shared types and constants for the per-target identity table.
package target_identity_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSeek,
    StOffer,
    StDone
  } daa_state_e;

  typedef struct packed {
    logic [6:0] sta_addr;
    logic       sta_valid;
    logic [6:0] dyn_addr;
    logic       dyn_valid;
  } entry_t;

  localparam logic [6:0] I3C_BCAST_ADDR = 7'h7E;
  localparam logic [6:0] HOT_JOIN_ADDR  = 7'h02;

endpackage

// File: rtl/target_addr_match.sv
// Combinational lowest-index address comparator over all target entries.
module target_addr_match
  import target_identity_pkg::*;
#(
  parameter int unsigned NUM_TARGETS = 2,
  parameter int unsigned IDX_W       = 1
) (
  input  logic [6:0]             addr_i,
  input  entry_t [NUM_TARGETS-1:0] entries_i,
  input  logic                   use_sta_i,
  input  logic [NUM_TARGETS-1:0] excl_i,
  output logic                   hit_o,
  output logic [IDX_W-1:0]       idx_o
);

  logic dyn_hit, sta_hit;

  always_comb begin
    hit_o   = 1'b0;
    idx_o   = '0;
    dyn_hit = 1'b0;
    sta_hit = 1'b0;
    if (addr_i != I3C_BCAST_ADDR) begin
      // Descending scan so the lowest matching index is written last.
      for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
        dyn_hit = entries_i[i].dyn_valid && (entries_i[i].dyn_addr == addr_i);
        sta_hit = use_sta_i && entries_i[i].sta_valid && !entries_i[i].dyn_valid &&
                  (entries_i[i].sta_addr == addr_i);
        if (!excl_i[i] && (dyn_hit || sta_hit)) begin
          hit_o = 1'b1;
          idx_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/target_identity_table.sv
// Static/dynamic address table per target, registered bus match and ENTDAA sequencer.
module target_identity_table
  import target_identity_pkg::*;
#(
  parameter int unsigned NUM_TARGETS = 2,
  parameter int unsigned IDX_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     csr_wr_i,
  input  logic [IDX_W-1:0]         csr_idx_i,
  input  logic [6:0]               csr_sta_addr_i,
  input  logic                     csr_sta_valid_i,
  input  logic [6:0]               csr_dyn_addr_i,
  input  logic                     csr_dyn_valid_i,
  input  logic [NUM_TARGETS*64-1:0] id_i,
  input  logic [6:0]               bus_addr_i,
  input  logic                     bus_addr_valid_i,
  output logic                     match_o,
  output logic [IDX_W-1:0]         match_idx_o,
  input  logic                     rstdaa_i,
  input  logic                     dasa_i,
  input  logic [6:0]               dasa_sta_addr_i,
  input  logic [6:0]               dasa_dyn_addr_i,
  input  logic                     daa_start_i,
  output logic                     daa_req_o,
  output logic [IDX_W-1:0]         daa_idx_o,
  output logic [63:0]              daa_id_o,
  input  logic                     daa_assign_i,
  input  logic [6:0]               daa_addr_i,
  input  logic                     daa_lost_i,
  input  logic                     daa_end_i,
  output logic                     daa_done_o,
  output logic [NUM_TARGETS*7-1:0] sta_addr_o,
  output logic [NUM_TARGETS-1:0]   sta_valid_o,
  output logic [NUM_TARGETS*7-1:0] dyn_addr_o,
  output logic [NUM_TARGETS-1:0]   dyn_valid_o,
  output logic [NUM_TARGETS-1:0]   addr_update_o,
  output logic                     assign_err_o
);

  entry_t [NUM_TARGETS-1:0] ent_q, ent_d;
  daa_state_e               state_q, state_d;
  logic [IDX_W-1:0]         daa_idx_q, daa_idx_d;
  logic [63:0]              daa_id_q, daa_id_d;
  logic                     daa_done_q, daa_done_d;
  logic                     match_q, match_d;
  logic [IDX_W-1:0]         match_idx_q, match_idx_d;
  logic [NUM_TARGETS-1:0]   upd_q, upd_d;
  logic                     err_q, err_d;

  logic                     bus_hit;
  logic [IDX_W-1:0]         bus_idx;
  logic                     dasa_hit, seek_hit;
  logic [IDX_W-1:0]         dasa_idx, seek_idx;
  logic                     asg_valid, asg_ok, dup_hit;
  logic [IDX_W-1:0]         asg_idx, dup_idx_unused;
  logic [6:0]               asg_addr;
  logic [NUM_TARGETS-1:0]   asg_excl;

  target_addr_match #(
    .NUM_TARGETS(NUM_TARGETS),
    .IDX_W      (IDX_W)
  ) u_bus_match (
    .addr_i   (bus_addr_i),
    .entries_i(ent_q),
    .use_sta_i(1'b1),
    .excl_i   ({NUM_TARGETS{1'b0}}),
    .hit_o    (bus_hit),
    .idx_o    (bus_idx)
  );

  assign match_d     = bus_addr_valid_i && bus_hit;
  assign match_idx_d = match_d ? bus_idx : '0;

  always_comb begin
    dasa_hit = 1'b0;
    dasa_idx = '0;
    seek_hit = 1'b0;
    seek_idx = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (ent_q[i].sta_valid && !ent_q[i].dyn_valid &&
          (ent_q[i].sta_addr == dasa_sta_addr_i)) begin
        dasa_hit = 1'b1;
        dasa_idx = IDX_W'(i);
      end
      if (!ent_q[i].dyn_valid) begin
        seek_hit = 1'b1;
        seek_idx = IDX_W'(i);
      end
    end
  end

  // At most one bus-side assignment per cycle; SETDASA takes the slot over a DAA assign.
  assign asg_valid = dasa_i ? dasa_hit : (daa_assign_i && (state_q == StOffer));
  assign asg_idx   = dasa_i ? dasa_idx : daa_idx_q;
  assign asg_addr  = dasa_i ? dasa_dyn_addr_i : daa_addr_i;

  always_comb begin
    asg_excl = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      asg_excl[i] = (asg_idx == IDX_W'(i));
    end
  end

  target_addr_match #(
    .NUM_TARGETS(NUM_TARGETS),
    .IDX_W      (IDX_W)
  ) u_dup_check (
    .addr_i   (asg_addr),
    .entries_i(ent_q),
    .use_sta_i(1'b0),
    .excl_i   (asg_excl),
    .hit_o    (dup_hit),
    .idx_o    (dup_idx_unused)
  );

  assign asg_ok = (asg_addr != I3C_BCAST_ADDR) && (asg_addr != 7'h00) && !dup_hit;

  always_comb begin
    ent_d = ent_q;
    upd_d = '0;
    err_d = 1'b0;
    if (rstdaa_i) begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        upd_d[i]           = ent_q[i].dyn_valid;
        ent_d[i].dyn_valid = 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        if (csr_wr_i && (csr_idx_i == IDX_W'(i)) &&
            !(asg_valid && (asg_idx == IDX_W'(i)))) begin
          ent_d[i].sta_addr  = csr_sta_addr_i;
          ent_d[i].sta_valid = csr_sta_valid_i;
          ent_d[i].dyn_addr  = csr_dyn_addr_i;
          ent_d[i].dyn_valid = csr_dyn_valid_i;
        end
      end
      if (asg_valid) begin
        if (asg_ok) begin
          for (int i = 0; i < NUM_TARGETS; i++) begin
            if (asg_idx == IDX_W'(i)) begin
              ent_d[i].dyn_addr  = asg_addr;
              ent_d[i].dyn_valid = 1'b1;
              upd_d[i]           = 1'b1;
            end
          end
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    daa_idx_d  = daa_idx_q;
    daa_id_d   = daa_id_q;
    daa_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (daa_start_i) state_d = StSeek;
      end
      StSeek: begin
        if (seek_hit) begin
          state_d   = StOffer;
          daa_idx_d = seek_idx;
          for (int i = 0; i < NUM_TARGETS; i++) begin
            if (seek_idx == IDX_W'(i)) daa_id_d = id_i[i*64 +: 64];
          end
        end else begin
          state_d    = StDone;
          daa_done_d = 1'b1;
        end
      end
      StOffer: begin
        if (daa_assign_i || daa_lost_i) state_d = StSeek;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (rstdaa_i || daa_end_i) begin
      state_d    = StIdle;
      daa_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q       <= '0;
      state_q     <= StIdle;
      daa_idx_q   <= '0;
      daa_id_q    <= '0;
      daa_done_q  <= 1'b0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      upd_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      ent_q       <= ent_d;
      state_q     <= state_d;
      daa_idx_q   <= daa_idx_d;
      daa_id_q    <= daa_id_d;
      daa_done_q  <= daa_done_d;
      match_q     <= match_d;
      match_idx_q <= match_idx_d;
      upd_q       <= upd_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    sta_addr_o  = '0;
    sta_valid_o = '0;
    dyn_addr_o  = '0;
    dyn_valid_o = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      sta_addr_o[i*7 +: 7] = ent_q[i].sta_addr;
      sta_valid_o[i]       = ent_q[i].sta_valid;
      dyn_addr_o[i*7 +: 7] = ent_q[i].dyn_addr;
      dyn_valid_o[i]       = ent_q[i].dyn_valid;
    end
  end

  assign match_o       = match_q;
  assign match_idx_o   = match_idx_q;
  assign daa_req_o     = (state_q == StOffer);
  assign daa_idx_o     = daa_idx_q;
  assign daa_id_o      = daa_id_q;
  assign daa_done_o    = daa_done_q;
  assign addr_update_o = upd_q;
  assign assign_err_o  = err_q;

endmodule

// File: doc/target_identity_table.md
Name: target_identity_table

Overview:
- Per-target addressing and identity state for a standby controller that presents NUM_TARGETS I3C targets: the main target, the virtual target, and further targets.
- Holds the static and dynamic addresses for each target. Bus-side CCC actions (ENTDAA, SETDASA, RSTDAA) and CSR writes both update them.
- Provides a registered bus-address match and a sequencer that offers targets one at a time during ENTDAA.
- Sits between the CSR configuration extraction and the target FSM / CCC decoder.

Parameters:
- NUM_TARGETS, 2, number of target entries; legal range 1..8.
- IDX_W, $clog2(NUM_TARGETS) with a minimum of 1, width of every entry index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- csr_wr_i  in  1  one-cycle CSR write strobe for entry csr_idx_i
- csr_idx_i  in  IDX_W  CSR target index
- csr_sta_addr_i  in  7  static address from CSR
- csr_sta_valid_i  in  1  static address valid
- csr_dyn_addr_i  in  7  dynamic address from CSR
- csr_dyn_valid_i  in  1  dynamic address valid
- id_i  in  NUM_TARGETS*64  per-entry {PID[47:0], BCR, DCR}, entry 0 in the LSBs
- bus_addr_i  in  7  address byte received after START/Sr
- bus_addr_valid_i  in  1  one-cycle qualifier for bus_addr_i
- match_o  out  1  registered: an entry matched
- match_idx_o  out  IDX_W  index of the matching entry
- rstdaa_i  in  1  RSTDAA broadcast pulse
- dasa_i  in  1  SETDASA pulse
- dasa_sta_addr_i  in  7  static address that SETDASA targeted
- dasa_dyn_addr_i  in  7  dynamic address assigned by SETDASA
- daa_start_i  in  1  ENTDAA received
- daa_req_o  out  1  an entry is being offered for arbitration
- daa_idx_o  out  IDX_W  index of the offered entry
- daa_id_o  out  64  ID of the offered entry
- daa_assign_i  in  1  arbitration won; the address byte has been received
- daa_addr_i  in  7  address assigned to the offered entry
- daa_lost_i  in  1  arbitration lost
- daa_end_i  in  1  controller ended ENTDAA (STOP)
- daa_done_o  out  1  one-cycle pulse: every entry now has a dynamic address
- sta_addr_o  out  NUM_TARGETS*7  per-entry static address
- sta_valid_o  out  NUM_TARGETS  per-entry static address valid
- dyn_addr_o  out  NUM_TARGETS*7  per-entry dynamic address
- dyn_valid_o  out  NUM_TARGETS  per-entry dynamic address valid
- addr_update_o  out  NUM_TARGETS  one-cycle pulse per entry on any bus-side dynamic-address change
- assign_err_o  out  1  one-cycle pulse when an assignment is rejected

Behaviour:
- Reset values: all outputs 0; all entry registers 0; FSM in IDLE.
- CSR write: on csr_wr_i, the entry at csr_idx_i loads all four address fields on the next edge.
  - csr_idx_i >= NUM_TARGETS: write is ignored.
  - CSR writes never pulse addr_update_o.
- Match: one-cycle latency from bus_addr_valid_i.
  - A dynamic address with dyn_valid set matches.
  - Otherwise a static address with sta_valid set and dyn_valid clear matches.
  - Several entries match: the lowest index wins.
  - 7'h7E never matches an entry.
  - match_o is 0 in any cycle after which bus_addr_valid_i was low.
- RSTDAA: clears dyn_valid for every entry.
  - Pulses addr_update_o for every entry that was previously valid.
  - Forces the FSM to IDLE.
- SETDASA: applies to the lowest entry with sta_valid set, sta_addr == dasa_sta_addr_i and dyn_valid clear.
  - That entry loads dasa_dyn_addr_i and sets dyn_valid.
  - No such entry: the pulse is ignored.
- Address validity check, applied to SETDASA and DAA assignments:
  - Rejected if the new address equals another entry's valid dynamic address, or equals 7'h7E or 7'h00.
  - A rejected assignment pulses assign_err_o and leaves the entry unchanged.
- Priority within one cycle, highest first: rstdaa_i, then bus assignment (dasa_i or daa_assign_i), then csr_wr_i.
  - The losing CSR write to the same entry is dropped; to a different entry it still applies.
- DAA FSM:
  - IDLE: daa_start_i goes to SEEK.
  - SEEK: one cycle; selects the lowest entry with dyn_valid clear. Found goes to OFFER; none goes to DONE.
  - OFFER: daa_req_o=1; daa_idx_o and daa_id_o are registered and stable.
    - daa_assign_i: store the address if valid (addr_update_o pulse), then go to SEEK.
    - If the assignment is rejected, pulse assign_err_o and go to SEEK; the same entry is re-offered.
    - daa_lost_i: go to SEEK; the same entry is re-offered on the next arbitration.
  - DONE: pulse daa_done_o, go to IDLE.
  - daa_end_i in any state goes to IDLE with no daa_done_o.
  - daa_start_i outside IDLE is ignored.
- A csr_wr_i that sets dyn_valid while the FSM is in OFFER for that entry does not abort the offer.

Decomposition:
- Shared package (target_identity_pkg): DAA FSM state enum; entry struct {sta_addr, sta_valid, dyn_addr, dyn_valid}; constants I3C_BCAST_ADDR=7'h7E and HOT_JOIN_ADDR=7'h02.
- One natural sub-module: target_addr_match, the combinational priority comparator. It is instantiated twice: once for bus match, once for the duplicate-address check.

Test Plan:
- CSR write entry1 sta=0x30 valid, then bus_addr=0x30 -> next cycle match_o=1, match_idx_o=1; bus_addr=0x31 -> match_o=0.
- NUM_TARGETS=2, no dynamic addresses; ENTDAA -> offer idx0 with id_i[63:0]; lost once -> idx0 re-offered; assign 0x08 -> offer idx1; assign 0x09 -> daa_done_o pulse; addr_update_o pulses 01 then 10.
- Entry0 dyn=0x08 valid; DAA assigns 0x08 to entry1 -> assign_err_o=1, entry1 unchanged, entry1 re-offered.
- SETDASA sta=0x30 dyn=0x12, with entry0 and entry1 both sta 0x30 -> only entry0 gets 0x12; bus_addr 0x30 then matches entry1.
- RSTDAA issued in the same cycle as daa_assign_i and csr_wr_i -> all dyn_valid=0, FSM IDLE, no assignment applied.
- rst_ni asserted during OFFER -> outputs 0 immediately, FSM IDLE after release.
